conv_loop_gen: RTL and testbench

- Nested loop-index generator that sequences the convolution datapath.
- Walks six loop counters in the fixed order rr > cc > mm > nn > ii > jj, where jj is innermost.
- Advances one step per cycle while the conv controller holds loop_en.
- Also produces input-feature-map row/column coordinates for the buffer address logic, plus the loop-boundary flags the controller uses to insert bias cycles and detect layer completion.

---
 rtl/conv_loop_gen.sv | 127 ++++++++++++
 tb/tb_conv_loop_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_loop_gen.sv
// Six-deep loop-index generator (rr > cc > mm > nn > ii > jj) for the conv datapath.
// Counters and coordinates update one cycle after a step. The boundary flags are combinational from registered state.
module conv_loop_gen #(
  parameter int DATA_SIZE = 16,
  parameter int LOOP_BIT  = 8,
  parameter int COORD_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_SIZE-1:0] R,
  input  logic [DATA_SIZE-1:0] C,
  input  logic [DATA_SIZE-1:0] M,
  input  logic [DATA_SIZE-1:0] N,
  input  logic [DATA_SIZE-1:0] K,
  input  logic [DATA_SIZE-1:0] S,
  input  logic                 loop_en,
  output logic [LOOP_BIT-1:0]  rr,
  output logic [LOOP_BIT-1:0]  cc,
  output logic [LOOP_BIT-1:0]  mm,
  output logic [LOOP_BIT-1:0]  nn,
  output logic [LOOP_BIT-1:0]  ii,
  output logic [LOOP_BIT-1:0]  jj,
  output logic                 inner_last,
  output logic                 all_last,
  output logic [COORD_BIT-1:0] in_row,
  output logic [COORD_BIT-1:0] in_col,
  output logic                 coord_vld,
  output logic                 wrap
);

  logic [DATA_SIZE-1:0] r_q, r_d, c_q, c_d, m_q, m_d, n_q, n_d, k_q, k_d, s_q, s_d;
  logic [LOOP_BIT-1:0]  rr_q, rr_d, cc_q, cc_d, mm_q, mm_d;
  logic [LOOP_BIT-1:0]  nn_q, nn_d, ii_q, ii_d, jj_q, jj_d;
  logic [COORD_BIT-1:0] in_row_q, in_row_d, in_col_q, in_col_d;
  logic                 coord_vld_q, coord_vld_d, wrap_q, wrap_d;

  logic rr_last, cc_last, mm_last, nn_last, ii_last, jj_last;
  logic cy_ii, cy_nn, cy_mm, cy_cc, cy_rr;

  function automatic logic at_last(input logic [LOOP_BIT-1:0] v, input logic [DATA_SIZE-1:0] b);
    return DATA_SIZE'(v) == (b - DATA_SIZE'(1));
  endfunction

  // A zero bound would never terminate its loop; treat it as a single iteration.
  function automatic logic [DATA_SIZE-1:0] fix_bound(input logic [DATA_SIZE-1:0] b);
    return (b == '0) ? DATA_SIZE'(1) : b;
  endfunction

  assign rr_last = at_last(rr_q, r_q);
  assign cc_last = at_last(cc_q, c_q);
  assign mm_last = at_last(mm_q, m_q);
  assign nn_last = at_last(nn_q, n_q);
  assign ii_last = at_last(ii_q, k_q);
  assign jj_last = at_last(jj_q, k_q);

  assign inner_last = nn_last && ii_last && jj_last;
  assign all_last   = inner_last && rr_last && cc_last && mm_last;

  // Carry into each counter from everything inside it.
  assign cy_ii = jj_last;
  assign cy_nn = cy_ii && ii_last;
  assign cy_mm = cy_nn && nn_last;
  assign cy_cc = cy_mm && mm_last;
  assign cy_rr = cy_cc && cc_last;

  always_comb begin
    r_d = r_q; c_d = c_q; m_d = m_q; n_d = n_q; k_d = k_q; s_d = s_q;
    rr_d = rr_q; cc_d = cc_q; mm_d = mm_q; nn_d = nn_q; ii_d = ii_q; jj_d = jj_q;
    in_row_d    = in_row_q;
    in_col_d    = in_col_q;
    coord_vld_d = 1'b0;
    wrap_d      = 1'b0;
    if (load) begin
      r_d = fix_bound(R);
      c_d = fix_bound(C);
      m_d = fix_bound(M);
      n_d = fix_bound(N);
      k_d = fix_bound(K);
      s_d = S;
      rr_d = '0; cc_d = '0; mm_d = '0; nn_d = '0; ii_d = '0; jj_d = '0;
    end else if (loop_en) begin
      coord_vld_d = 1'b1;
      wrap_d      = all_last;
      // Modular arithmetic at COORD_BIT equals full-width product then truncate.
      in_row_d = COORD_BIT'(rr_q) * COORD_BIT'(s_q) + COORD_BIT'(ii_q);
      in_col_d = COORD_BIT'(cc_q) * COORD_BIT'(s_q) + COORD_BIT'(jj_q);
      jj_d = jj_last ? '0 : jj_q + LOOP_BIT'(1);
      if (cy_ii) ii_d = ii_last ? '0 : ii_q + LOOP_BIT'(1);
      if (cy_nn) nn_d = nn_last ? '0 : nn_q + LOOP_BIT'(1);
      if (cy_mm) mm_d = mm_last ? '0 : mm_q + LOOP_BIT'(1);
      if (cy_cc) cc_d = cc_last ? '0 : cc_q + LOOP_BIT'(1);
      if (cy_rr) rr_d = rr_last ? '0 : rr_q + LOOP_BIT'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= DATA_SIZE'(1); c_q <= DATA_SIZE'(1); m_q <= DATA_SIZE'(1);
      n_q <= DATA_SIZE'(1); k_q <= DATA_SIZE'(1); s_q <= DATA_SIZE'(1);
      rr_q <= '0; cc_q <= '0; mm_q <= '0; nn_q <= '0; ii_q <= '0; jj_q <= '0;
      in_row_q    <= '0;
      in_col_q    <= '0;
      coord_vld_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      r_q <= r_d; c_q <= c_d; m_q <= m_d; n_q <= n_d; k_q <= k_d; s_q <= s_d;
      rr_q <= rr_d; cc_q <= cc_d; mm_q <= mm_d; nn_q <= nn_d; ii_q <= ii_d; jj_q <= jj_d;
      in_row_q    <= in_row_d;
      in_col_q    <= in_col_d;
      coord_vld_q <= coord_vld_d;
      wrap_q      <= wrap_d;
    end
  end

  assign rr        = rr_q;
  assign cc        = cc_q;
  assign mm        = mm_q;
  assign nn        = nn_q;
  assign ii        = ii_q;
  assign jj        = jj_q;
  assign in_row    = in_row_q;
  assign in_col    = in_col_q;
  assign coord_vld = coord_vld_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_conv_loop_gen.sv
// Directed bench for conv_loop_gen: a reference loop model pushes expected
// post-edge state to a scoreboard queue, popped and compared after each edge.
module tb_conv_loop_gen;
  localparam int DS = 16;
  localparam int LB = 8;
  localparam int CB = 16;

  logic          clk = 1'b0;
  logic          rst, load, loop_en;
  logic [DS-1:0] R, C, M, N, K, S;
  logic [LB-1:0] rr, cc, mm, nn, ii, jj;
  logic          inner_last, all_last, coord_vld, wrap;
  logic [CB-1:0] in_row, in_col;

  conv_loop_gen #(.DATA_SIZE(DS), .LOOP_BIT(LB), .COORD_BIT(CB)) dut (
    .clk(clk), .rst(rst), .load(load), .R(R), .C(C), .M(M), .N(N), .K(K), .S(S),
    .loop_en(loop_en), .rr(rr), .cc(cc), .mm(mm), .nn(nn), .ii(ii), .jj(jj),
    .inner_last(inner_last), .all_last(all_last), .in_row(in_row), .in_col(in_col),
    .coord_vld(coord_vld), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt [6];
    int row, col, vld, wrp;
  } exp_t;

  exp_t sb[$];
  int   b[6];        // loop bounds in counter order rr,cc,mm,nn,ii,jj
  int   b_s;
  int   m[6];        // model counters rr,cc,mm,nn,ii,jj
  int   e_row, e_col;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_wrap = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int fixb(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int m_inner();
    return (m[3] == b[3]-1 && m[4] == b[4]-1 && m[5] == b[5]-1) ? 1 : 0;
  endfunction

  function automatic int m_all();
    return (m_inner() == 1 && m[0] == b[0]-1 && m[1] == b[1]-1 && m[2] == b[2]-1) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      b[i] = 1;
      m[i] = 0;
    end
    b_s = 1; e_row = 0; e_col = 0;
  endtask

  task automatic cfg(input int r, input int c, input int mv, input int n, input int k, input int s);
    R = DS'(r); C = DS'(c); M = DS'(mv); N = DS'(n); K = DS'(k); S = DS'(s);
  endtask

  // One clock: drive inputs, predict, then compare after the edge.
  task automatic cycle(input bit ld, input bit en);
    exp_t e, g;
    load = ld; loop_en = en;
    e.vld = 0; e.wrp = 0;
    if (ld) begin
      b[0] = fixb(int'(R)); b[1] = fixb(int'(C)); b[2] = fixb(int'(M));
      b[3] = fixb(int'(N)); b[4] = fixb(int'(K)); b[5] = b[4];
      b_s  = int'(S);
      for (int i = 0; i < 6; i++) m[i] = 0;
    end else if (en) begin
      e_row = (m[0] * b_s + m[4]) & 32'hFFFF;
      e_col = (m[1] * b_s + m[5]) & 32'hFFFF;
      e.vld = 1;
      e.wrp = m_all();
      for (int i = 5; i >= 0; i--) begin
        m[i]++;
        if (m[i] < b[i]) break;
        m[i] = 0;
      end
    end
    e.cnt = m; e.row = e_row; e.col = e_col;
    sb.push_back(e);
    @(posedge clk);
    #1;
    load = 1'b0; loop_en = 1'b0;
    if (wrap === 1'b1) n_wrap++;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      g = sb.pop_front();
      chk("rr", 32'(rr), g.cnt[0]);
      chk("cc", 32'(cc), g.cnt[1]);
      chk("mm", 32'(mm), g.cnt[2]);
      chk("nn", 32'(nn), g.cnt[3]);
      chk("ii", 32'(ii), g.cnt[4]);
      chk("jj", 32'(jj), g.cnt[5]);
      chk("coord_vld", 32'(coord_vld), g.vld);
      chk("wrap", 32'(wrap), g.wrp);
      if (g.vld == 1) begin
        chk("in_row", 32'(in_row), g.row);
        chk("in_col", 32'(in_col), g.col);
      end
      chk("inner_last", 32'(inner_last), m_inner());
      chk("all_last", 32'(all_last), m_all());
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; loop_en = 1'b0;
    cfg(0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    chk("rst_jj", 32'(jj), 0);
    chk("rst_rr", 32'(rr), 0);
    chk("rst_in_row", 32'(in_row), 0);
    chk("rst_vld", 32'(coord_vld), 0);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_all_last", 32'(all_last), 1);
    @(posedge clk); #1; rst = 1'b0;

    // K=3 inner loop only
    cfg(1, 1, 1, 1, 3, 1);
    cycle(1, 0);
    n_wrap = 0;
    for (int i = 0; i < 9; i++) cycle(0, 1);
    chk("t1_wrap_count", n_wrap, 1);
    chk("t1_wrap_last", 32'(wrap), 1);

    // outer loops, stride 2
    cfg(2, 2, 2, 2, 1, 2);
    cycle(1, 0);
    n_wrap = 0;
    for (int i = 0; i < 16; i++) cycle(0, 1);
    chk("t2_wrap_count", n_wrap, 1);
    cycle(0, 0);
    chk("t2_wrap_single", 32'(wrap), 0);

    // loop_en gaps
    cfg(1, 1, 1, 1, 3, 1);
    cycle(1, 0);
    cycle(0, 1); chk("t3_jj_a", 32'(jj), 1);
    cycle(0, 0); chk("t3_jj_b", 32'(jj), 1); chk("t3_vld_b", 32'(coord_vld), 0);
    cycle(0, 0); chk("t3_jj_c", 32'(jj), 1); chk("t3_vld_c", 32'(coord_vld), 0);
    cycle(0, 1); chk("t3_jj_d", 32'(jj), 2);

    // load beats simultaneous loop_en
    cycle(0, 1);
    cycle(0, 1); chk("t4_pre_jj", 32'(jj), 1);
    cfg(1, 1, 1, 1, 5, 1);
    cycle(1, 1);
    chk("t4_jj_zero", 32'(jj), 0);
    chk("t4_ii_zero", 32'(ii), 0);
    for (int i = 0; i < 4; i++) cycle(0, 1);
    chk("t4_jj_top", 32'(jj), 4);
    cycle(0, 1);
    chk("t4_jj_wrap", 32'(jj), 0);
    chk("t4_ii_inc", 32'(ii), 1);

    // zero bounds latch as one
    cfg(0, 1, 1, 1, 0, 3);
    cycle(1, 0);
    chk("t5_all_last", 32'(all_last), 1);
    cycle(0, 1);
    chk("t5_wrap", 32'(wrap), 1);

    // asynchronous reset mid-run
    cfg(2, 2, 2, 2, 3, 1);
    cycle(1, 0);
    for (int i = 0; i < 11; i++) cycle(0, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_jj", 32'(jj), 0);
    chk("ar_ii", 32'(ii), 0);
    chk("ar_nn", 32'(nn), 0);
    chk("ar_in_row", 32'(in_row), 0);
    chk("ar_in_col", 32'(in_col), 0);
    chk("ar_vld", 32'(coord_vld), 0);
    chk("ar_inner_last", 32'(inner_last), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cycle(0, 0);
    cycle(0, 0);
    chk("ar_inner_hold", 32'(inner_last), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
